fpu_dispatch: RTL and testbench

Issue-side controller for the fixed-point unit: accepts one arithmetic request at a time from the core, drives the FPU operand/opcode lines, and waits for the multi-cycle divider's `busy` handshake. It captures the result and holds it on a valid/ready writeback port until the register file takes it. It sits between the core's execute stage and the FPU, and is the only agent allowed to drive the FPU inputs.

---
 rtl/fpu_dispatch.sv | 94 +++++++++
 tb/tb_fpu_dispatch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: single-outstanding issue controller between the core and the fixed-point unit
module fpu_dispatch #(
  parameter int TAG_W       = 5,
  parameter int DIV_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       fpu_op,
  output logic [63:0]      fpu_a,
  output logic [63:0]      fpu_b,
  input  logic             fpu_busy,
  input  logic [63:0]      fpu_res,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [63:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_err
);
  localparam int WD_W = $clog2(DIV_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, EXEC, DIV_DRAIN, DIV_LAUNCH, DIV_RUN, WB} state_t;
  state_t st, nxt;
  logic [3:0] op_r;
  logic [63:0] a_r, b_r, data_r;
  logic [TAG_W-1:0] tag_r;
  logic [WD_W-1:0] wd, wd_d;
  logic seen_busy, err_r, accept, legal, waiting, timeout, done;
  assign accept    = req_valid && req_ready;
  assign legal     = !(req_op inside {4'd7, 4'd8, 4'd14, 4'd15});
  assign waiting   = st == DIV_DRAIN || st == DIV_RUN;
  assign timeout   = waiting && wd >= WD_W'(DIV_TIMEOUT - 1);
  assign done      = st == DIV_RUN && seen_busy && !fpu_busy;
  assign req_ready = st == IDLE;
  assign wb_valid  = st == WB;
  assign fpu_op    = st == EXEC ? op_r : (st == DIV_LAUNCH || st == DIV_RUN) ? 4'b0011 : 4'b0000;
  assign fpu_a     = a_r;
  assign fpu_b     = b_r;
  assign wb_data   = data_r;
  assign wb_tag    = tag_r;
  assign wb_err    = err_r;
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:       nxt = !accept ? IDLE : !legal ? WB : req_op == 4'b0011 ? DIV_DRAIN : EXEC;
      EXEC:       nxt = WB;
      DIV_DRAIN:  nxt = timeout ? WB : !fpu_busy ? DIV_LAUNCH : DIV_DRAIN;
      DIV_LAUNCH: nxt = DIV_RUN;
      DIV_RUN:    nxt = (timeout || done) ? WB : DIV_RUN;
      WB:         nxt = wb_ready ? IDLE : WB;
      default:    nxt = IDLE;
    endcase
    wd_d = ((nxt == DIV_DRAIN && st != DIV_DRAIN) || nxt == DIV_LAUNCH) ? '0 :
           (waiting && wd != WD_W'(DIV_TIMEOUT)) ? wd + 1'b1 : wd;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      tag_r     <= '0;
      wd        <= '0;
      seen_busy <= 1'b0;
      data_r    <= '0;
      err_r     <= 1'b0;
    end else begin
      st <= nxt;
      wd <= wd_d;
      if (accept) begin
        tag_r  <= req_tag;
        data_r <= '0;
        err_r  <= !legal;
        if (legal) begin
          op_r <= req_op;
          a_r  <= req_a;
          b_r  <= req_b;
        end
      end
      if (st == EXEC) data_r <= fpu_res;
      if (st == DIV_LAUNCH) seen_busy <= 1'b0;
      else if (st == DIV_RUN && fpu_busy) seen_busy <= 1'b1;
      if (done) data_r <= fpu_res;
      else if (timeout) begin
        data_r <= '0;
        err_r  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: directed table and sequence checks of fpu_dispatch against a stub FPU
module tb_fpu_dispatch;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [4:0] req_tag = '0;
  logic [3:0] fpu_op;
  logic [63:0] fpu_a, fpu_b, fpu_res;
  logic fpu_busy;
  logic wb_valid;
  logic wb_ready = 1'b1;
  logic [63:0] wb_data;
  logic [4:0] wb_tag;
  logic wb_err;
  logic [3:0] div_cnt = '0;
  logic stuck = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  tag;
    logic [63:0] data;
    logic        err;
  } vec_t;
  vec_t vt[10];
  fpu_dispatch #(.TAG_W(5), .DIV_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_busy(fpu_busy), .fpu_res(fpu_res),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag), .wb_err(wb_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) div_cnt <= div_cnt != 0 ? div_cnt - 4'd1 : fpu_op == 4'b0011 ? 4'd10 : 4'd0;
  assign fpu_busy = div_cnt != 0 || stuck;
  always_comb begin
    fpu_res = fpu_a ^ fpu_b;
    case (fpu_op)
      4'd0:  fpu_res = fpu_a + fpu_b;
      4'd1:  fpu_res = fpu_a - fpu_b;
      4'd3:  fpu_res = fpu_busy ? 64'hDEAD : 64'h8000;
      4'd12: fpu_res = $signed(fpu_a) < $signed(fpu_b) ? fpu_a : fpu_b;
      4'd13: fpu_res = $signed(fpu_a) < $signed(fpu_b) ? fpu_b : fpu_a;
      default: ;
    endcase
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_idle_fpu();
    int n = 0;
    while (fpu_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("fpu_idle_wait", 64'(fpu_busy), 64'd0);
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_data"}, wb_data, 64'd0);
    chk({tag, "_wb_tag"}, 64'(wb_tag), 64'd0);
    chk({tag, "_wb_err"}, 64'(wb_err), 64'd0);
    chk({tag, "_fpu_op"}, 64'(fpu_op), 64'd0);
    chk({tag, "_fpu_a"}, fpu_a, 64'd0);
    chk({tag, "_fpu_b"}, fpu_b, 64'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, bad;
    vt[0] = '{4'd0,  64'h18000, 64'h10000, 5'd3,  64'h28000, 1'b0};
    vt[1] = '{4'd1,  64'd5, 64'd8, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vt[2] = '{4'd12, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vt[3] = '{4'd13, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd2, 64'd3, 1'b0};
    vt[4] = '{4'd6,  64'hF0, 64'h0F, 5'd31, 64'hFF, 1'b0};
    vt[5] = '{4'd10, 64'hA0, 64'h0A, 5'd10, 64'hAA, 1'b0};
    vt[6] = '{4'd7,  64'd1, 64'd2, 5'd4,  64'd0, 1'b1};
    vt[7] = '{4'd8,  64'd5, 64'd6, 5'd6,  64'd0, 1'b1};
    vt[8] = '{4'd14, 64'd9, 64'd9, 5'd8,  64'd0, 1'b1};
    vt[9] = '{4'd15, 64'd7, 64'd1, 5'd30, 64'd0, 1'b1};
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
      chk($sformatf("v%0d_fpu_op", i), 64'(fpu_op), vt[i].err ? 64'd0 : 64'(vt[i].op));
      lat = 1;
      while (!wb_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("v%0d_latency", i), 64'(lat), vt[i].err ? 64'd1 : 64'd2);
      chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].data);
      chk($sformatf("v%0d_wb_tag", i), 64'(wb_tag), 64'(vt[i].tag));
      chk($sformatf("v%0d_wb_err", i), 64'(wb_err), 64'(vt[i].err));
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), 64'({wb_valid, req_ready}), 64'b01);
    end
    wb_ready = 1'b0;
    issue(4'd12, 64'd10, 64'hFFFF_FFFF_FFFF_FFFB, 5'd9);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 4'd0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d_wb_valid", i), 64'(wb_valid), 64'd1);
      chk($sformatf("bp%0d_wb_data", i), wb_data, 64'hFFFF_FFFF_FFFF_FFFB);
      chk($sformatf("bp%0d_wb_tag", i), 64'(wb_tag), 64'd9);
      chk($sformatf("bp%0d_wb_err", i), 64'(wb_err), 64'd0);
      chk($sformatf("bp%0d_req_ready", i), 64'(req_ready), 64'd0);
      if (i == 5) wb_ready = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_release_idle", 64'({wb_valid, req_ready}), 64'b01);
    @(negedge clk);
    wait_idle_fpu();
    issue(4'd3, 64'h40000, 64'h80000, 5'd12);
    chk("div_drain_op", 64'(fpu_op), 64'd0);
    @(negedge clk);
    chk("div_launch_op", 64'(fpu_op), 64'd3);
    lat = 2;
    bad = 0;
    while (!wb_valid && lat < 60) begin
      if (fpu_op !== 4'd3) bad++;
      @(negedge clk);
      lat++;
    end
    chk("div_run_op_held", 64'(bad), 64'd0);
    chk("div_latency", 64'(lat), 64'd14);
    chk("div_wb_data", wb_data, 64'h8000);
    chk("div_wb_tag", 64'(wb_tag), 64'd12);
    chk("div_wb_err", 64'(wb_err), 64'd0);
    @(negedge clk);
    stuck = 1'b1;
    issue(4'd3, 64'd1, 64'd1, 5'd20);
    lat = 1;
    bad = 0;
    while (!wb_valid && lat < 100) begin
      if (fpu_op !== 4'd0) bad++;
      @(negedge clk);
      lat++;
    end
    chk("to_quiet_op", 64'(bad), 64'd0);
    chk("to_latency", 64'(lat), 64'd21);
    chk("to_wb_data", wb_data, 64'd0);
    chk("to_wb_err", 64'(wb_err), 64'd1);
    chk("to_wb_tag", 64'(wb_tag), 64'd20);
    stuck = 1'b0;
    @(negedge clk);
    wait_idle_fpu();
    issue(4'd3, 64'h55, 64'h66, 5'd5);
    lat = 1;
    while (div_cnt != 4'd7 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_reached_run", 64'(fpu_op), 64'd3);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    chk("midrst_busy_still", 64'(fpu_busy), 64'd1);
    reset = 1'b1;
    issue(4'd3, 64'h77, 64'h88, 5'd17);
    lat = 1;
    bad = 0;
    while (fpu_op !== 4'd3 && lat < 40) begin
      if (fpu_op !== 4'd0) bad++;
      @(negedge clk);
      lat++;
    end
    chk("redo_drain_quiet", 64'(bad), 64'd0);
    chk("redo_launch_cycle", 64'(lat), 64'd7);
    while (!wb_valid && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("redo_wb_cycle", 64'(lat), 64'd19);
    chk("redo_wb_data", wb_data, 64'h8000);
    chk("redo_wb_tag", 64'(wb_tag), 64'd17);
    chk("redo_wb_err", 64'(wb_err), 64'd0);
    @(negedge clk);
    chk("redo_back_idle", 64'({wb_valid, req_ready}), 64'b01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
